// File: rtl/pulse_monitor_if.sv
// Pulse monitor bus: tick input plus measurement and status outputs.
interface pulse_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             pulse_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             err_early;
    logic             err_missing;

    modport master (
        output pulse_in,
        input  period, period_valid, locked, err_early, err_missing
    );

    modport slave (
        input  pulse_in,
        output period, period_valid, locked, err_early, err_missing
    );
endinterface

// File: rtl/pulse_monitor.sv
// Measures the interval between rising edges of pulse_in, flags early and
// missing pulses, and declares lock after LOCK_N consecutive in-window intervals.
module pulse_monitor #(
    parameter int unsigned NOMINAL = 4801,
    parameter int unsigned TOL     = 48,
    parameter int unsigned LOCK_N  = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    pulse_monitor_if.slave bus
);
    localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [GOOD_W-1:0] LOCK_G = GOOD_W'(LOCK_N);
    localparam logic [CNT_W-1:0]  WIN_LO = CNT_W'(NOMINAL - TOL);
    localparam logic [CNT_W-1:0]  WIN_HI = CNT_W'(NOMINAL + TOL);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               pulse_d_q;
    logic               period_valid_q, period_valid_d;
    logic               locked_q, locked_d;
    logic               err_early_q, err_early_d;
    logic               err_missing_q, err_missing_d;
    logic               edge_w;
    logic [GOOD_W-1:0]  good_inc;

    assign edge_w   = bus.pulse_in & ~pulse_d_q;
    assign good_inc = (good_q == LOCK_G) ? good_q : good_q + GOOD_W'(1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_d         = good_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_early_d    = 1'b0;
        err_missing_d  = 1'b0;
        case (state_q)
            TRACK, LOCKED: begin
                if (edge_w) begin
                    // An edge on the timeout clock is still in-window, so it wins.
                    cnt_d          = CNT_W'(1);
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (cnt_q < WIN_LO) begin
                        err_early_d = 1'b1;
                        good_d      = '0;
                        state_d     = TRACK;
                    end else begin
                        good_d  = good_inc;
                        state_d = (good_inc == LOCK_G) ? LOCKED : TRACK;
                    end
                end else if (cnt_q == WIN_HI) begin
                    err_missing_d = 1'b1;
                    good_d        = '0;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
                if (edge_w) begin
                    cnt_d   = CNT_W'(1);
                    good_d  = '0;
                    state_d = TRACK;
                end
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            good_q         <= '0;
            period_q       <= '0;
            pulse_d_q      <= 1'b1;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_early_q    <= 1'b0;
            err_missing_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            period_q       <= period_d;
            pulse_d_q      <= bus.pulse_in;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_early_q    <= err_early_d;
            err_missing_q  <= err_missing_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.err_early    = err_early_q;
    assign bus.err_missing  = err_missing_q;
endmodule

// File: tb/tb_pulse_monitor.sv
// Scoreboard bench for pulse_monitor: directed edge schedule with expected events queued.
module tb_pulse_monitor;
    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned last;

    typedef struct {
        bit          pv;
        bit          ee;
        bit          em;
        int unsigned per;
        int unsigned c;
    } ev_t;
    ev_t q[$];

    pulse_monitor_if #(.CNT_W(16)) bus ();

    pulse_monitor #(
        .NOMINAL(4801),
        .TOL    (48),
        .LOCK_N (3),
        .CNT_W  (16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached at cyc=%0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int unsigned got, input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic exp_pv(input int unsigned per, input int unsigned c, input bit early);
        ev_t e;
        e.pv = 1'b1; e.ee = early; e.em = 1'b0; e.per = per; e.c = c;
        q.push_back(e);
    endtask

    task automatic exp_em(input int unsigned c);
        ev_t e;
        e.pv = 1'b0; e.ee = 1'b0; e.em = 1'b1; e.per = 0; e.c = c;
        q.push_back(e);
    endtask

    // Always called from the phase 1 unit after a rising edge.
    task automatic wait_to(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // pulse_in is first sampled high by the rising edge numbered t.
    task automatic edge_at(input int unsigned t, input int unsigned width);
        wait_to(t - 1);
        bus.pulse_in = 1'b1;
        repeat (width) begin
            @(posedge clk);
            #1;
        end
        bus.pulse_in = 1'b0;
        last = t;
    endtask

    // Monitor: pops one expectation per output event.
    always @(negedge clk) begin
        if (bus.period_valid || bus.err_early || bus.err_missing) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL event: got unexpected pv=%0b ee=%0b em=%0b period=%0d cyc=%0d, required no event",
                         bus.period_valid, bus.err_early, bus.err_missing, bus.period, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (bus.period_valid !== e.pv || bus.err_early !== e.ee || bus.err_missing !== e.em ||
                    cyc != e.c || (e.pv && bus.period != 16'(e.per))) begin
                    errors++;
                    $display("FAIL event: got pv=%0b ee=%0b em=%0b period=%0d cyc=%0d, required pv=%0b ee=%0b em=%0b period=%0d cyc=%0d",
                             bus.period_valid, bus.err_early, bus.err_missing, bus.period, cyc,
                             e.pv, e.ee, e.em, e.per, e.c);
                end
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        bus.pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_period", bus.period, 0);
        chk("reset_pv", bus.period_valid, 0);
        chk("reset_locked", bus.locked, 0);
        chk("reset_early", bus.err_early, 0);
        chk("reset_missing", bus.err_missing, 0);
        reset_n = 1'b1;

        // Nominal train: reference edge, then four 4801-cycle intervals.
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                edge_at(100, 1);
            end else begin
                exp_pv(4801, last + 4801, 1'b0);
                edge_at(last + 4801, 1);
            end
            if (k == 2) chk("lock_before_third", bus.locked, 0);
            if (k == 3) chk("lock_after_third", bus.locked, 1);
        end
        chk("period_hold", bus.period, 4801);

        // Early interval drops lock; wide pulses then relock.
        exp_pv(4700, last + 4700, 1'b1);
        edge_at(last + 4700, 1);
        chk("lock_after_early", bus.locked, 0);
        for (int k = 0; k < 3; k++) begin
            exp_pv(4801, last + 4801, 1'b0);
            edge_at(last + 4801, 10);
            if (k == 1) chk("relock_pending", bus.locked, 0);
            if (k == 2) chk("relock", bus.locked, 1);
        end

        // Window edges: NOMINAL+TOL coincides with the timeout clock.
        exp_pv(4849, last + 4849, 1'b0);
        edge_at(last + 4849, 1);
        chk("lock_after_4849", bus.locked, 1);
        exp_pv(4753, last + 4753, 1'b0);
        edge_at(last + 4753, 1);
        chk("lock_after_4753", bus.locked, 1);

        // Missing pulse, then a fresh reference and a just-too-early interval.
        exp_em(last + 4849);
        wait_to(last + 4855);
        chk("lock_after_missing", bus.locked, 0);
        edge_at(last + 6000, 1);
        exp_pv(4752, last + 4752, 1'b1);
        edge_at(last + 4752, 1);
        chk("lock_after_4752", bus.locked, 0);

        // Relock, then reset mid-interval with pulse_in high across release.
        for (int k = 0; k < 3; k++) begin
            exp_pv(4801, last + 4801, 1'b0);
            edge_at(last + 4801, 1);
        end
        chk("lock_before_reset", bus.locked, 1);
        wait_to(last + 2000);
        reset_n      = 1'b0;
        bus.pulse_in = 1'b1;
        #1;
        chk("async_rst_locked", bus.locked, 0);
        chk("async_rst_period", bus.period, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        wait_to(cyc + 5);
        bus.pulse_in = 1'b0;
        edge_at(cyc + 20, 1);
        exp_pv(4801, last + 4801, 1'b0);
        edge_at(last + 4801, 1);

        wait_to(last + 10);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
